// File: rtl/frame_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : frame_pixel_streamer
// Description : Frame buffer and raster-order pixel source for the 2-D conv
//               engine. The host loads the frame RAM through a simple write
//               port. A 'go' request pulses the engine start, streams every
//               pixel with an optional idle gap after each one, then waits for
//               the engine done, giving up after DONE_TIMEOUT cycles.
//               Optional feature macro STREAMER_RESULT_CNT_EN adds a
//               saturating count of engine result_valid cycles per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pixel_streamer #(
   parameter int IMG_WIDTH    = 32,
   parameter int IMG_HEIGHT   = 32,
   parameter int GAP_CYCLES   = 0,
   parameter int DONE_TIMEOUT = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    wr_en_i,
   input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr_i,
   input  logic [7:0]                              wr_data_i,
   input  logic                                    go_i,
   input  logic                                    pause_i,
   input  logic                                    eng_done_i,
`ifdef STREAMER_RESULT_CNT_EN
   input  logic                                    res_valid_i,
   output logic [15:0]                             res_count_o,
`endif
   output logic                                    start_signal_o,
   output logic [7:0]                              pixel_out_o,
   output logic                                    pixel_valid_o,
   output logic                                    busy_o,
   output logic                                    frame_done_o,
   output logic                                    timeout_err_o,
   output logic                                    wr_drop_o
);

   localparam int C_NPIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int C_AW   = $clog2(C_NPIX);
   localparam int C_XW   = (IMG_WIDTH    > 1) ? $clog2(IMG_WIDTH)      : 1;
   localparam int C_YW   = (IMG_HEIGHT   > 1) ? $clog2(IMG_HEIGHT)     : 1;
   localparam int C_GW   = (GAP_CYCLES   > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int C_TW   = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT)   : 1;

   localparam logic [C_XW-1:0] C_X_LAST   = C_XW'(IMG_WIDTH - 1);
   localparam logic [C_YW-1:0] C_Y_LAST   = C_YW'(IMG_HEIGHT - 1);
   localparam logic [C_GW-1:0] C_GAP_LOAD = C_GW'(GAP_CYCLES);
   localparam logic [C_TW-1:0] C_TO_LAST  = C_TW'(DONE_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_STREAM    = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_FINISH    = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [C_XW-1:0] x_q;
   logic [C_YW-1:0] y_q;
   logic [C_AW-1:0] rd_addr_q;
   logic [C_GW-1:0] gap_q;
   logic [C_TW-1:0] wait_q;
   logic [7:0]      mem_q [C_NPIX];
   logic [7:0]      pixel_q;
   logic            valid_q;
   logic            start_q;
   logic            frame_done_q;
   logic            timeout_q;
   logic            wr_drop_q;

   logic            w_go_acc;
   logic            w_emit;
   logic            w_last_pix;
   logic            w_timeout;

   // A pixel leaves on any START/STREAM cycle that is neither paused nor
   // inside the post-pixel gap; the START cycle itself emits pixel (0,0).
   assign w_go_acc   = (state_q == S_IDLE) && go_i;
   assign w_emit     = ((state_q == S_START) || (state_q == S_STREAM)) && !pause_i && (gap_q == '0);
   assign w_last_pix = (x_q == C_X_LAST) && (y_q == C_Y_LAST);
   assign w_timeout  = (state_q == S_WAIT_DONE) && !eng_done_i && (wait_q == C_TO_LAST);

   // Next-state selection for the frame sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (go_i) state_d = S_START;
         S_START:     state_d = (w_emit && w_last_pix) ? S_WAIT_DONE : S_STREAM;
         S_STREAM:    if (w_emit && w_last_pix) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (eng_done_i || (wait_q == C_TO_LAST)) state_d = S_FINISH;
         S_FINISH:    state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Sequencer state, output strobes, raster/gap/timeout counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         wr_drop_q    <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         rd_addr_q    <= '0;
         gap_q        <= '0;
         wait_q       <= '0;
      end else begin
         state_q      <= state_d;
         start_q      <= w_go_acc;
         valid_q      <= w_emit;
         frame_done_q <= (state_q == S_WAIT_DONE) && (state_d == S_FINISH);
         wr_drop_q    <= wr_en_i && (state_q != S_IDLE);
         if (w_go_acc) begin
            timeout_q <= 1'b0;
         end else if (w_timeout) begin
            timeout_q <= 1'b1;
         end
         if (w_go_acc) begin
            x_q       <= '0;
            y_q       <= '0;
            rd_addr_q <= '0;
            gap_q     <= '0;
         end else if (w_emit) begin
            gap_q     <= C_GAP_LOAD;
            rd_addr_q <= rd_addr_q + 1'b1;
            if (x_q == C_X_LAST) begin
               x_q <= '0;
               y_q <= (y_q == C_Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
               x_q <= x_q + 1'b1;
            end
         end else if ((gap_q != '0) && !pause_i) begin
            gap_q <= gap_q - 1'b1;
         end
         wait_q <= (state_q == S_WAIT_DONE) ? wait_q + 1'b1 : '0;
      end
   end

   // Frame RAM: host writes only land while idle; contents survive rst
   always_ff @(posedge clk) begin
      if (wr_en_i && (state_q == S_IDLE)) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered pixel read, refreshed only on emitted pixels so it holds otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_q <= 8'h00;
      end else if (w_emit) begin
         pixel_q <= mem_q[rd_addr_q];
      end
   end

`ifdef STREAMER_RESULT_CNT_EN
   logic [15:0] res_count_q;

   // Saturating count of engine result cycles, restarted by each accepted go
   always_ff @(posedge clk) begin
      if (rst) begin
         res_count_q <= 16'h0000;
      end else if (w_go_acc) begin
         res_count_q <= 16'h0000;
      end else if ((state_q != S_IDLE) && res_valid_i && (res_count_q != 16'hFFFF)) begin
         res_count_q <= res_count_q + 16'h0001;
      end
   end

   assign res_count_o = res_count_q;
`endif

   assign start_signal_o = start_q;
   assign pixel_out_o    = pixel_q;
   assign pixel_valid_o  = valid_q;
   assign busy_o         = (state_q != S_IDLE);
   assign frame_done_o   = frame_done_q;
   assign timeout_err_o  = timeout_q;
   assign wr_drop_o      = wr_drop_q;

endmodule
`default_nettype wire
